ball_pixel_renderer: RTL and testbench

Downstream consumer of the ball animation stage's ball_x_pos/ball_y_pos. Takes the VGA timing generator's raw counters and syncs. Latches the ball position once per frame at the start of vertical blanking, so the ball never tears mid-frame. Produces 12-bit RGB plus delayed syncs through a fixed 2-cycle pipeline, for the VGA output pins.

---
 rtl/ball_pixel_renderer.sv | 154 +++++++++++++++
 tb/tb_ball_pixel_renderer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ball_pixel_renderer.sv
// Ball pixel renderer: latches ball position at the start of vertical blanking
// and renders RGB444 through a 2-stage pipeline. Option: PLAYFIELD_BORDER_EN.
module ball_pixel_renderer #(
  parameter int          BALL_SIZE    = 10,
  parameter int          H_ACT_START  = 144,
  parameter int          H_ACT_END    = 784,
  parameter int          V_ACT_START  = 35,
  parameter int          V_ACT_END    = 515,
  parameter logic [11:0] BALL_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] BORDER_COLOR = 12'h0F0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] ball_x_pos,
  input  logic [9:0] ball_y_pos,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       pixel_active,
  output logic [7:0] frame_count
);

  localparam logic [10:0] HS = 11'(H_ACT_START);
  localparam logic [10:0] HE = 11'(H_ACT_END);
  localparam logic [10:0] VS = 11'(V_ACT_START);
  localparam logic [10:0] VE = 11'(V_ACT_END);
  localparam logic [10:0] BS = 11'(BALL_SIZE);

  logic [10:0] h11;
  logic [10:0] v11;

  assign h11 = {1'b0, hcount};
  assign v11 = {1'b0, vcount};

  logic [9:0] bx_q, bx_d;
  logic [9:0] by_q, by_d;
  logic [7:0] fc_q, fc_d;
  logic       latch;

  assign latch = (hcount == 10'd0) && (v11 == VE);

  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    fc_d = fc_q;
    if (latch) begin
      bx_d = ball_x_pos;
      by_d = ball_y_pos;
      fc_d = fc_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bx_q <= '0;
      by_q <= '0;
      fc_q <= '0;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
      fc_q <= fc_d;
    end
  end

  // Stage 1: decode region and ball hit against the held position.
  logic [10:0] bx_end;
  logic [10:0] by_end;
  logic        act1_d, ball1_d, bord1_d;
  logic        act1_q, ball1_q, bord1_q;
  logic        hs1_q, vs1_q;

  assign bx_end = {1'b0, bx_q} + BS;
  assign by_end = {1'b0, by_q} + BS;

  always_comb begin
    act1_d = (h11 >= HS) && (h11 < HE) &&
             (v11 >= VS) && (v11 < VE);
    ball1_d = (h11 >= {1'b0, bx_q}) && (h11 < bx_end) &&
              (v11 >= {1'b0, by_q}) && (v11 < by_end);
  end

`ifdef PLAYFIELD_BORDER_EN
  always_comb begin
    bord1_d = (h11 == HS) || (h11 == HE - 11'd1) ||
              (v11 == VS) || (v11 == VE - 11'd1);
  end
`else
  logic unused_border;
  assign unused_border = ^BORDER_COLOR;
  assign bord1_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      act1_q  <= 1'b0;
      ball1_q <= 1'b0;
      bord1_q <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
    end else begin
      act1_q  <= act1_d;
      ball1_q <= ball1_d;
      bord1_q <= bord1_d;
      hs1_q   <= hsync_in;
      vs1_q   <= vsync_in;
    end
  end

  // Stage 2: colour select, border over ball over background.
  logic [11:0] rgb_d, rgb_q;
  logic        act2_q, hs2_q, vs2_q;

  always_comb begin
    rgb_d = 12'h000;
    if (act1_q) begin
      if (bord1_q)
        rgb_d = BORDER_COLOR;
      else if (ball1_q)
        rgb_d = BALL_COLOR;
      else
        rgb_d = BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb_q  <= '0;
      act2_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
    end else begin
      rgb_q  <= rgb_d;
      act2_q <= act1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  assign red          = rgb_q[11:8];
  assign green        = rgb_q[7:4];
  assign blue         = rgb_q[3:0];
  assign hsync_out    = hs2_q;
  assign vsync_out    = vs2_q;
  assign pixel_active = act2_q;
  assign frame_count  = fc_q;

endmodule

// File: tb/tb_ball_pixel_renderer.sv
// Scoreboard bench for ball_pixel_renderer with a frame-level reference model.
// Define PLAYFIELD_BORDER_EN for both bench and RTL to cover the border option.
module tb_ball_pixel_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hcount, vcount, ball_x_pos, ball_y_pos;
  logic       hsync_in, vsync_in;
  logic [3:0] red, green, blue;
  logic       hsync_out, vsync_out, pixel_active;
  logic [7:0] frame_count;

  always #5 clk = ~clk;

  ball_pixel_renderer dut (
    .clk(clk), .reset(reset),
    .hcount(hcount), .vcount(vcount),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .ball_x_pos(ball_x_pos), .ball_y_pos(ball_y_pos),
    .red(red), .green(green), .blue(blue),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .pixel_active(pixel_active), .frame_count(frame_count)
  );

  typedef struct {
    logic [11:0] rgb;
    bit act;
    bit hs;
    bit vs;
    int fc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int mbx = 0, mby = 0, mfc = 0;
  bit in_rst = 1'b1;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic exp_t model(int h, int v, int hs, int vs,
                                 int bx, int by);
    exp_t e;
    bit act, ball, bord;
    act  = h >= 144 && h < 784 && v >= 35 && v < 515;
    ball = h >= bx && h < bx + 10 && v >= by && v < by + 10;
    bord = 1'b0;
`ifdef PLAYFIELD_BORDER_EN
    bord = h == 144 || h == 783 || v == 35 || v == 514;
`endif
    if (!act) e.rgb = 12'h000;
    else if (bord) e.rgb = 12'h0F0;
    else if (ball) e.rgb = 12'hFFF;
    else e.rgb = 12'h000;
    e.act = act;
    e.hs = hs[0];
    e.vs = vs[0];
    e.fc = 0;
    return e;
  endfunction

  task automatic drive(int h, int v, int hs, int vs, int xp, int yp);
    exp_t e;
    @(negedge clk);
    hcount = 10'(h);
    vcount = 10'(v);
    hsync_in = hs[0];
    vsync_in = vs[0];
    ball_x_pos = 10'(xp);
    ball_y_pos = 10'(yp);
    e = model(h, v, hs, vs, mbx, mby);
    if (h == 0 && v == 515) begin
      mbx = xp;
      mby = yp;
      mfc = (mfc + 1) % 256;
    end
    e.fc = mfc;
    q.push_back(e);
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    reset = 1'b0;
    in_rst = 1'b1;
    hcount = 10'd0;
    vcount = 10'd515;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    ball_x_pos = 10'd300;
    ball_y_pos = 10'd200;
    q.delete();
    mbx = 0;
    mby = 0;
    mfc = 0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
    in_rst = 1'b0;
    hcount = 10'd1;
    vcount = 10'd0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (in_rst) begin
      chk("rst_rgb", 32'({red, green, blue}), 32'h0);
      chk("rst_hsync", 32'(hsync_out), 32'h1);
      chk("rst_vsync", 32'(vsync_out), 32'h1);
      chk("rst_active", 32'(pixel_active), 32'h0);
      chk("rst_frame_count", 32'(frame_count), 32'h0);
    end else if (q.size() >= 2) begin
      e = q.pop_front();
      chk("rgb", 32'({red, green, blue}), 32'(e.rgb));
      chk("pixel_active", 32'(pixel_active), 32'(e.act));
      chk("hsync_out", 32'(hsync_out), 32'(e.hs));
      chk("vsync_out", 32'(vsync_out), 32'(e.vs));
      chk("frame_count", 32'(frame_count), 32'(q[0].fc));
    end
  end

  task automatic rand_run(int n);
    int h, v, xp, yp;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < 70) begin
        xp = $urandom_range(100, 800);
        yp = $urandom_range(20, 530);
      end else begin
        xp = $urandom_range(0, 1023);
        yp = $urandom_range(0, 1023);
      end
      if ($urandom_range(0, 39) == 0) begin
        h = 0;
        v = 515;
      end else if ($urandom_range(0, 1) == 1) begin
        h = mbx + int'($urandom_range(0, 13)) - 2;
        v = mby + int'($urandom_range(0, 13)) - 2;
        if (h < 0) h = 0;
        if (h > 799) h = 799;
        if (v < 0) v = 0;
        if (v > 524) v = 524;
      end else begin
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 524);
      end
      drive(h, v, $urandom_range(0, 1), $urandom_range(0, 1), xp, yp);
    end
  endtask

  initial begin
    reset = 1'b0;
    hcount = '0;
    vcount = '0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    ball_x_pos = '0;
    ball_y_pos = '0;
    do_reset(5);
    drive(5, 100, 1, 1, 300, 200);
    drive(0, 515, 1, 0, 300, 200);
    drive(300, 200, 1, 1, 300, 200);
    drive(309, 209, 1, 1, 300, 200);
    drive(310, 200, 1, 1, 300, 200);
    drive(299, 200, 1, 1, 300, 200);
    drive(300, 210, 1, 1, 300, 200);
    drive(0, 515, 1, 0, 300, 200);
    drive(300, 100, 1, 1, 400, 200);
    drive(300, 150, 1, 1, 400, 200);
    drive(305, 205, 1, 1, 400, 200);
    drive(405, 205, 1, 1, 400, 200);
    drive(0, 515, 1, 0, 400, 200);
    drive(405, 205, 1, 1, 400, 200);
    drive(305, 205, 1, 1, 400, 200);
    drive(0, 515, 1, 0, 45, 200);
    drive(50, 205, 1, 1, 45, 200);
    drive(150, 205, 1, 1, 45, 200);
    drive(0, 515, 1, 0, 650, 100);
    drive(655, 105, 1, 1, 650, 100);
    drive(656, 105, 0, 1, 650, 100);
    drive(657, 105, 0, 1, 650, 100);
    drive(658, 105, 1, 1, 650, 100);
    drive(0, 515, 1, 0, 780, 30);
    drive(783, 36, 1, 1, 780, 30);
    drive(782, 36, 1, 1, 780, 30);
    drive(781, 35, 1, 1, 780, 30);
    drive(144, 35, 1, 1, 780, 30);
    drive(145, 36, 1, 1, 780, 30);
    drive(0, 515, 1, 0, 1020, 1020);
    drive(799, 524, 1, 1, 1020, 1020);
    drive(5, 5, 1, 1, 1020, 1020);
    do_reset(3);
    for (int i = 0; i < 256; i++)
      drive(0, 515, 1, 0, 200 + i, 100);
    drive(300, 200, 1, 1, 0, 0);
    rand_run(20000);
    do_reset(3);
    drive(300, 200, 1, 1, 300, 200);
    rand_run(10000);
    repeat (3) drive(1, 0, 1, 1, 0, 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
